// File: rtl/alu_op_pkg.sv
// Op-code encodings and instruction field constants shared by the ALU op sequencer and its decoder.
// Pure declarations: no logic, no latency, no flow control.
package alu_op_pkg;

    typedef logic [4:0] op_t;

    localparam op_t OP_NON  = 5'd0;
    localparam op_t OP_ADD  = 5'd1;
    localparam op_t OP_SUB  = 5'd2;
    localparam op_t OP_AND  = 5'd3;
    localparam op_t OP_OR   = 5'd4;
    localparam op_t OP_XOR  = 5'd5;
    localparam op_t OP_NOR  = 5'd6;
    localparam op_t OP_SLT  = 5'd7;
    localparam op_t OP_SLTU = 5'd8;
    localparam op_t OP_SLL  = 5'd9;
    localparam op_t OP_SRL  = 5'd10;
    localparam op_t OP_SRA  = 5'd11;
    localparam op_t OP_SLLV = 5'd12;
    localparam op_t OP_SRLV = 5'd13;
    localparam op_t OP_SRAV = 5'd14;
    localparam op_t OP_LUI  = 5'd15;
    localparam op_t OP_MUL  = 5'd16;
    localparam op_t OP_MULU = 5'd17;
    localparam op_t OP_DIV  = 5'd18;
    localparam op_t OP_DIVU = 5'd19;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10,
        ALU_ITYPE = 2'b11
    } alu_sel_e;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_SRA   = 6'b000011;
    localparam logic [5:0] FUNCT_SLLV  = 6'b000100;
    localparam logic [5:0] FUNCT_SRLV  = 6'b000110;
    localparam logic [5:0] FUNCT_SRAV  = 6'b000111;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    localparam logic [2:0] IOP_ADDI  = 3'b000;
    localparam logic [2:0] IOP_SLTI  = 3'b010;
    localparam logic [2:0] IOP_SLTIU = 3'b011;
    localparam logic [2:0] IOP_ANDI  = 3'b100;
    localparam logic [2:0] IOP_ORI   = 3'b101;
    localparam logic [2:0] IOP_XORI  = 3'b110;
    localparam logic [2:0] IOP_LUI   = 3'b111;

    typedef struct packed {
        op_t  op;
        logic illegal;
        logic is_md;
        logic is_div;
    } dec_t;

endpackage

// File: rtl/alu_op_decode.sv
// Field decoder: alu_op/funct/i_op -> {op, illegal, is_md, is_div}.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the enclosing sequencer owns all flow control.
module alu_op_decode
    import alu_op_pkg::*;
#(
    parameter bit HAS_MD = 1'b1
) (
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    input  logic [2:0] i_op,
    output dec_t       dec_o
);

    always_comb begin
        dec_o = '{op: OP_NON, illegal: 1'b0, is_md: 1'b0, is_div: 1'b0};
        case (alu_sel_e'(alu_op))
            ALU_ADD: dec_o.op = OP_ADD;
            ALU_SUB: dec_o.op = OP_SUB;
            ALU_RTYPE: begin
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: dec_o.op = OP_ADD;
                    FUNCT_SUB, FUNCT_SUBU: dec_o.op = OP_SUB;
                    FUNCT_AND:   dec_o.op = OP_AND;
                    FUNCT_OR:    dec_o.op = OP_OR;
                    FUNCT_XOR:   dec_o.op = OP_XOR;
                    FUNCT_NOR:   dec_o.op = OP_NOR;
                    FUNCT_SLT:   dec_o.op = OP_SLT;
                    FUNCT_SLTU:  dec_o.op = OP_SLTU;
                    FUNCT_SLL:   dec_o.op = OP_SLL;
                    FUNCT_SRL:   dec_o.op = OP_SRL;
                    FUNCT_SRA:   dec_o.op = OP_SRA;
                    FUNCT_SLLV:  dec_o.op = OP_SLLV;
                    FUNCT_SRLV:  dec_o.op = OP_SRLV;
                    FUNCT_SRAV:  dec_o.op = OP_SRAV;
                    FUNCT_MULT:  begin dec_o.op = OP_MUL;  dec_o.is_md = 1'b1; end
                    FUNCT_MULTU: begin dec_o.op = OP_MULU; dec_o.is_md = 1'b1; end
                    FUNCT_DIV:   begin dec_o.op = OP_DIV;  dec_o.is_md = 1'b1; dec_o.is_div = 1'b1; end
                    FUNCT_DIVU:  begin dec_o.op = OP_DIVU; dec_o.is_md = 1'b1; dec_o.is_div = 1'b1; end
                    default:     dec_o.illegal = 1'b1;
                endcase
                // Without a mul-div unit these functs are unsupported, not silently dropped.
                if (!HAS_MD && dec_o.is_md) begin
                    dec_o = '{op: OP_NON, illegal: 1'b1, is_md: 1'b0, is_div: 1'b0};
                end
            end
            ALU_ITYPE: begin
                case (i_op)
                    IOP_ADDI:  dec_o.op = OP_ADD;
                    IOP_SLTI:  dec_o.op = OP_SLT;
                    IOP_SLTIU: dec_o.op = OP_SLTU;
                    IOP_ANDI:  dec_o.op = OP_AND;
                    IOP_ORI:   dec_o.op = OP_OR;
                    IOP_XORI:  dec_o.op = OP_XOR;
                    IOP_LUI:   dec_o.op = OP_LUI;
                    default:   dec_o.illegal = 1'b1;
                endcase
            end
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU op decoder with valid/ready handshake and mul-div latency sequencing.
// Latency: one cycle from accept to op/out_valid; mul-div ops hold busy for MUL_LAT/DIV_LAT cycles.
// Backpressure: in_ready drops while out_valid && !out_ready or while a mul-div op is busy.
module alu_op_sequencer
    import alu_op_pkg::*;
#(
    parameter int OP_W    = 5,
    parameter bit HAS_MD  = 1'b1,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [5:0]      funct,
    input  logic [2:0]      i_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] op,
    output logic            illegal,
    output logic            md_busy,
    output logic            md_start,
    output logic            md_done,
    output logic            md_abort
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t MUL_CNT = cnt_t'(MUL_LAT - 1);
    localparam cnt_t DIV_CNT = cnt_t'(DIV_LAT - 1);

    dec_t            dec;
    logic            accept;

    logic            out_valid_q, out_valid_d;
    logic [OP_W-1:0] op_q,        op_d;
    logic            illegal_q,   illegal_d;
    logic            md_busy_q,   md_busy_d;
    cnt_t            cnt_q,       cnt_d;
    logic            md_start_q,  md_start_d;
    logic            md_done_q,   md_done_d;
    logic            md_abort_q,  md_abort_d;

    alu_op_decode #(
        .HAS_MD (HAS_MD)
    ) u_decode (
        .alu_op (alu_op),
        .funct  (funct),
        .i_op   (i_op),
        .dec_o  (dec)
    );

    assign in_ready = !md_busy_q && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        op_d        = op_q;
        illegal_d   = illegal_q;
        md_busy_d   = md_busy_q;
        cnt_d       = cnt_q;
        md_start_d  = 1'b0;
        md_abort_d  = 1'b0;

        if (md_busy_q) begin
            if (cnt_q == '0) begin
                md_busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            out_valid_d = 1'b1;
            op_d        = OP_W'(dec.op);
            illegal_d   = dec.illegal;
            if (dec.is_md) begin
                md_busy_d  = 1'b1;
                md_start_d = 1'b1;
                cnt_d      = dec.is_div ? DIV_CNT : MUL_CNT;
            end
        end

        // A flush landing on the final latency cycle lets the op complete rather than abort.
        if (flush) begin
            out_valid_d = 1'b0;
            op_d        = OP_W'(OP_NON);
            illegal_d   = 1'b0;
            md_busy_d   = 1'b0;
            cnt_d       = '0;
            md_start_d  = 1'b0;
            md_abort_d  = md_busy_q && (cnt_q != '0);
        end

        md_done_d = md_busy_d && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            op_q        <= OP_W'(OP_NON);
            illegal_q   <= 1'b0;
            md_busy_q   <= 1'b0;
            cnt_q       <= '0;
            md_start_q  <= 1'b0;
            md_done_q   <= 1'b0;
            md_abort_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            op_q        <= op_d;
            illegal_q   <= illegal_d;
            md_busy_q   <= md_busy_d;
            cnt_q       <= cnt_d;
            md_start_q  <= md_start_d;
            md_done_q   <= md_done_d;
            md_abort_q  <= md_abort_d;
        end
    end

    assign out_valid = out_valid_q;
    assign op        = op_q;
    assign illegal   = illegal_q;
    assign md_busy   = md_busy_q;
    assign md_start  = md_start_q;
    assign md_done   = md_done_q;
    assign md_abort  = md_abort_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: default build, a HAS_MD=0 build and a MUL_LAT=1 build
// share one stimulus stream; expected values are hand-computed op codes and cycle counts.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, flush, in_valid, out_ready;
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic [2:0] i_op;

    logic       in_ready, out_valid, illegal, md_busy, md_start, md_done, md_abort;
    logic [4:0] op;
    logic       n_in_ready, n_out_valid, n_illegal, n_md_busy, n_md_start, n_md_done, n_md_abort;
    logic [4:0] n_op;
    logic       l_in_ready, l_out_valid, l_illegal, l_md_busy, l_md_start, l_md_done, l_md_abort;
    logic [4:0] l_op;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] a;
        logic [5:0] f;
        logic [2:0] i;
        logic [4:0] op;
        logic       ill;
    } vec_t;
    vec_t vecs [14];

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .i_op(i_op), .out_valid(out_valid), .out_ready(out_ready),
        .op(op), .illegal(illegal), .md_busy(md_busy), .md_start(md_start), .md_done(md_done),
        .md_abort(md_abort)
    );

    alu_op_sequencer #(.HAS_MD(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
        .alu_op(alu_op), .funct(funct), .i_op(i_op), .out_valid(n_out_valid), .out_ready(out_ready),
        .op(n_op), .illegal(n_illegal), .md_busy(n_md_busy), .md_start(n_md_start),
        .md_done(n_md_done), .md_abort(n_md_abort)
    );

    alu_op_sequencer #(.MUL_LAT(1), .DIV_LAT(2)) dut_l (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(l_in_ready),
        .alu_op(alu_op), .funct(funct), .i_op(i_op), .out_valid(l_out_valid), .out_ready(out_ready),
        .op(l_op), .illegal(l_illegal), .md_busy(l_md_busy), .md_start(l_md_start),
        .md_done(l_md_done), .md_abort(l_md_abort)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 2'b00; funct = 6'd0; i_op = 3'd0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        checks++; if (op !== 5'd0) begin errors++; $display("FAIL rst_op: got %0d want 0", op); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %0b want 0", illegal); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rst_md_busy: got %0b want 0", md_busy); end
        checks++; if ({md_start, md_done, md_abort} !== 3'b000) begin errors++; $display("FAIL rst_pulses: got %b want 000", {md_start, md_done, md_abort}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_decode();
        vecs = '{
            '{2'b00, 6'b000000, 3'b000, 5'd1,  1'b0},
            '{2'b01, 6'b000000, 3'b000, 5'd2,  1'b0},
            '{2'b10, 6'b100010, 3'b000, 5'd2,  1'b0},
            '{2'b10, 6'b100001, 3'b000, 5'd1,  1'b0},
            '{2'b10, 6'b100100, 3'b000, 5'd3,  1'b0},
            '{2'b10, 6'b100111, 3'b000, 5'd6,  1'b0},
            '{2'b10, 6'b101011, 3'b000, 5'd8,  1'b0},
            '{2'b10, 6'b000000, 3'b000, 5'd9,  1'b0},
            '{2'b10, 6'b000011, 3'b000, 5'd11, 1'b0},
            '{2'b10, 6'b000111, 3'b000, 5'd14, 1'b0},
            '{2'b10, 6'b000001, 3'b000, 5'd0,  1'b1},
            '{2'b11, 6'b000000, 3'b111, 5'd15, 1'b0},
            '{2'b11, 6'b000000, 3'b001, 5'd0,  1'b1},
            '{2'b11, 6'b000000, 3'b011, 5'd8,  1'b0}
        };
        out_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            in_valid = 1'b1; alu_op = vecs[k].a; funct = vecs[k].f; i_op = vecs[k].i;
            tick();
            checks++; if (op !== vecs[k].op) begin errors++; $display("FAIL dec_op[%0d]: got %0d want %0d", k, op, vecs[k].op); end
            checks++; if (illegal !== vecs[k].ill) begin errors++; $display("FAIL dec_illegal[%0d]: got %0b want %0b", k, illegal, vecs[k].ill); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dec_valid[%0d]: got %0b want 1", k, out_valid); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dec_drain: out_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_no_md();
        in_valid = 1'b1; alu_op = 2'b10; funct = 6'b011010; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (n_op !== 5'd0) begin errors++; $display("FAIL nomd_op: got %0d want 0", n_op); end
        checks++; if (n_illegal !== 1'b1) begin errors++; $display("FAIL nomd_illegal: got %0b want 1", n_illegal); end
        checks++; if ({n_md_busy, n_md_start} !== 2'b00) begin errors++; $display("FAIL nomd_busy_start: got %b want 00", {n_md_busy, n_md_start}); end
        checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL div_busy_pre_flush: got %0b want 1", md_busy); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (md_abort !== 1'b1) begin errors++; $display("FAIL div_abort: got %0b want 1", md_abort); end
        checks++; if ({md_busy, out_valid, op} !== 7'd0) begin errors++; $display("FAIL div_flush_state: got busy=%0b valid=%0b op=%0d want 0", md_busy, out_valid, op); end
        tick();
        checks++; if ({md_abort, md_done} !== 2'b00) begin errors++; $display("FAIL div_abort_pulse: got %b want 00", {md_abort, md_done}); end
    endtask

    task automatic test_div();
        in_valid = 1'b1; alu_op = 2'b10; funct = 6'b011010; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if ({md_start, md_busy, in_ready, md_done} !== 4'b1100) begin errors++; $display("FAIL div_t1: got start,busy,rdy,done=%b want 1100", {md_start, md_busy, in_ready, md_done}); end
        checks++; if (op !== 5'd18) begin errors++; $display("FAIL div_op: got %0d want 18", op); end
        for (int k = 2; k <= 32; k++) begin
            tick();
            checks++;
            if ({md_start, md_busy, in_ready, md_done} !== {3'b010, (k == 32)}) begin
                errors++; $display("FAIL div_t%0d: got start,busy,rdy,done=%b want %b", k, {md_start, md_busy, in_ready, md_done}, {3'b010, (k == 32)});
            end
        end
        tick();
        checks++; if ({md_busy, in_ready, md_done} !== 3'b010) begin errors++; $display("FAIL div_t33: got busy,rdy,done=%b want 010", {md_busy, in_ready, md_done}); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; alu_op = 2'b00;
        tick();
        alu_op = 2'b01;
        for (int k = 0; k < 3; k++) begin
            checks++; if ({out_valid, op, in_ready} !== {1'b1, 5'd1, 1'b0}) begin errors++; $display("FAIL bp_hold[%0d]: got valid=%0b op=%0d rdy=%0b want 1,1,0", k, out_valid, op, in_ready); end
            tick();
        end
        checks++; if (op !== 5'd1) begin errors++; $display("FAIL bp_hold_last: got %0d want 1", op); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_rdy: got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if ({out_valid, op} !== {1'b1, 5'd2}) begin errors++; $display("FAIL bp_next_op: got valid=%0b op=%0d want 1,2", out_valid, op); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b want 0", out_valid); end
    endtask

    task automatic test_mult_flush();
        in_valid = 1'b1; alu_op = 2'b10; funct = 6'b011000; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if ({md_start, op} !== {1'b1, 5'd16}) begin errors++; $display("FAIL mul_start: got start=%0b op=%0d want 1,16", md_start, op); end
        checks++; if ({l_md_start, l_md_done, l_md_busy} !== 3'b111) begin errors++; $display("FAIL lat1_same_cycle: got start,done,busy=%b want 111", {l_md_start, l_md_done, l_md_busy}); end
        tick();
        checks++; if ({md_start, md_busy, md_done} !== 3'b010) begin errors++; $display("FAIL mul_cnt2: got start,busy,done=%b want 010", {md_start, md_busy, md_done}); end
        checks++; if ({l_md_busy, l_md_done, l_in_ready} !== 3'b001) begin errors++; $display("FAIL lat1_after: got busy,done,rdy=%b want 001", {l_md_busy, l_md_done, l_in_ready}); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if ({md_abort, md_busy, md_done} !== 3'b100) begin errors++; $display("FAIL mul_abort: got abort,busy,done=%b want 100", {md_abort, md_busy, md_done}); end
        checks++; if (l_md_abort !== 1'b0) begin errors++; $display("FAIL lat1_no_abort: got %0b want 0", l_md_abort); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if ({md_abort, md_done, in_ready} !== 3'b001) begin errors++; $display("FAIL mul_post_abort[%0d]: got abort,done,rdy=%b want 001", k, {md_abort, md_done, in_ready}); end
        end
    endtask

    task automatic test_flush_at_done();
        in_valid = 1'b1; alu_op = 2'b10; funct = 6'b011001; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if ({md_done, md_busy} !== 2'b11) begin errors++; $display("FAIL fad_done: got done,busy=%b want 11", {md_done, md_busy}); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if ({md_abort, md_busy, md_done} !== 3'b000) begin errors++; $display("FAIL fad_no_abort: got abort,busy,done=%b want 000", {md_abort, md_busy, md_done}); end
    endtask

    task automatic test_reset_mid_div();
        in_valid = 1'b1; alu_op = 2'b10; funct = 6'b011011; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (21) tick();
        checks++; if ({md_busy, md_done} !== 2'b10) begin errors++; $display("FAIL rmd_busy: got busy,done=%b want 10", {md_busy, md_done}); end
        rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, illegal, md_busy, md_start, md_done, md_abort} !== 6'd0) begin errors++; $display("FAIL rmd_async: got %b want 000000", {out_valid, illegal, md_busy, md_start, md_done, md_abort}); end
        checks++; if ({op, in_ready} !== {5'd0, 1'b1}) begin errors++; $display("FAIL rmd_op_rdy: got op=%0d rdy=%0b want 0,1", op, in_ready); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if ({md_start, md_done, md_abort, out_valid} !== 4'b0000) begin errors++; $display("FAIL rmd_release: got %b want 0000", {md_start, md_done, md_abort, out_valid}); end
        in_valid = 1'b1; alu_op = 2'b11; i_op = 3'b100;
        tick();
        in_valid = 1'b0;
        checks++; if ({out_valid, op, illegal} !== {1'b1, 5'd3, 1'b0}) begin errors++; $display("FAIL rmd_first_op: got valid=%0b op=%0d ill=%0b want 1,3,0", out_valid, op, illegal); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode();
        test_no_md();
        test_div();
        test_backpressure();
        test_mult_flush();
        test_flush_at_done();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
